// File: rtl/riscv_core_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_mul_pkg
// Description : Shared multiplier definitions: op-select encodings and the
//               output-buffer occupancy state.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_core_mul_pkg;

    // Op select carried alongside each product
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage : riscv_core_mul_pkg
`default_nettype wire

// File: rtl/riscv_core_mul_out_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_mul_out_if
// Description : Product-in / result-out handshake bundle of the multiplier
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_core_mul_out_if #(
    parameter int XLEN = 64,
    parameter int PW   = 2*XLEN+2
) ();

    logic [PW-1:0]   i_mul_out_product;
    logic [1:0]      i_mul_out_control;
    logic            i_mul_out_isword;
    logic [4:0]      i_mul_out_rd;
    logic            i_mul_out_valid;
    logic            o_mul_out_ready;
    logic            i_mul_out_flush;
    logic [XLEN-1:0] o_mul_out_result;
    logic [4:0]      o_mul_out_rd;
    logic            o_mul_out_valid;
    logic            i_mul_out_ready;

    // Environment side: supplies products, consumes results
    modport master (
        output i_mul_out_product, i_mul_out_control, i_mul_out_isword,
               i_mul_out_rd, i_mul_out_valid, i_mul_out_flush, i_mul_out_ready,
        input  o_mul_out_ready, o_mul_out_result, o_mul_out_rd, o_mul_out_valid
    );

    // Output stage side
    modport slave (
        input  i_mul_out_product, i_mul_out_control, i_mul_out_isword,
               i_mul_out_rd, i_mul_out_valid, i_mul_out_flush, i_mul_out_ready,
        output o_mul_out_ready, o_mul_out_result, o_mul_out_rd, o_mul_out_valid
    );

endinterface : riscv_core_mul_out_if
`default_nettype wire

// File: rtl/riscv_core_mul_out_fmt.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_mul_out_fmt
// Description : Selects the architectural result from the raw product:
//               low half, high half, or sign-extended low word.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_mul_out_fmt
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PW   = 2*XLEN+2
) (
    input  wire logic [PW-1:0]   i_product,
    input  wire logic [1:0]      i_control,
    input  wire logic            i_isword,
    output logic      [XLEN-1:0] o_result
);

    // The two extra product bits only exist to make signed/unsigned
    // operand extension uniform; they never reach the result.
    logic w_unused_hi;
    assign w_unused_hi = ^i_product[PW-1:2*XLEN];

    // Word ops ignore the op select; otherwise MUL takes the low half
    always_comb begin
        o_result = i_product[XLEN-1:0];
        if (i_isword) begin
            o_result = {{(XLEN-32){i_product[31]}}, i_product[31:0]};
        end else if (i_control != OP_MUL) begin
            o_result = i_product[2*XLEN-1:XLEN];
        end
    end

endmodule : riscv_core_mul_out_fmt
`default_nettype wire

// File: rtl/riscv_core_mul_out.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_mul_out
// Description : Multiplier output stage: formats the product and holds it in
//               a two-entry in-order buffer toward writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_mul_out
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PW   = 2*XLEN+2
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    riscv_core_mul_out_if.slave bus
);

    logic [XLEN-1:0] w_fmt_result;
    logic            w_push;
    logic            w_pop;
    buf_state_t      w_state_nxt;

    buf_state_t      r_state;
    logic            r_valid;
    logic            r_ready;
    logic [XLEN-1:0] r_head_res;
    logic [4:0]      r_head_rd;
    logic [XLEN-1:0] r_tail_res;
    logic [4:0]      r_tail_rd;

    riscv_core_mul_out_fmt #(
        .XLEN (XLEN),
        .PW   (PW)
    ) u_fmt (
        .i_product (bus.i_mul_out_product),
        .i_control (bus.i_mul_out_control),
        .i_isword  (bus.i_mul_out_isword),
        .o_result  (w_fmt_result)
    );

    assign w_push = bus.i_mul_out_valid && r_ready && !bus.i_mul_out_flush;
    assign w_pop  = r_valid && bus.i_mul_out_ready;

    // Next occupancy; flush wins over any push or pop
    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_mul_out_flush) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: if (w_push)            w_state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (w_push && !w_pop)         w_state_nxt = BUF_FULL;
                    else if (w_pop && !w_push)    w_state_nxt = BUF_EMPTY;
                end
                BUF_FULL:  if (w_pop)             w_state_nxt = BUF_ONE;
                default:                          w_state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // Buffer state, registered handshake flags and entry storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= BUF_EMPTY;
            r_valid    <= 1'b0;
            r_ready    <= 1'b1;
            r_head_res <= '0;
            r_head_rd  <= '0;
            r_tail_res <= '0;
            r_tail_rd  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != BUF_EMPTY);
            r_ready <= (w_state_nxt != BUF_FULL);
            if (!bus.i_mul_out_flush) begin
                case (r_state)
                    BUF_EMPTY: begin
                        if (w_push) begin
                            r_head_res <= w_fmt_result;
                            r_head_rd  <= bus.i_mul_out_rd;
                        end
                    end
                    BUF_ONE: begin
                        // Simultaneous pop lets the new entry become head
                        if (w_push && w_pop) begin
                            r_head_res <= w_fmt_result;
                            r_head_rd  <= bus.i_mul_out_rd;
                        end else if (w_push) begin
                            r_tail_res <= w_fmt_result;
                            r_tail_rd  <= bus.i_mul_out_rd;
                        end
                    end
                    BUF_FULL: begin
                        if (w_pop) begin
                            r_head_res <= r_tail_res;
                            r_head_rd  <= r_tail_rd;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_mul_out_ready  = r_ready;
    assign bus.o_mul_out_valid  = r_valid;
    assign bus.o_mul_out_result = r_head_res;
    assign bus.o_mul_out_rd     = r_head_rd;

endmodule : riscv_core_mul_out
`default_nettype wire
